pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS-Lite pipeline. Drives write-enable and

---
 rtl/pipe_hazard_ctrl_pkg.sv | 80 ++++++++
 rtl/pipe_hazard_ctrl_lu.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encodings,
// the architectural zero register and the bundle of pipeline controls.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    localparam logic [4:0] REG_ZERO    = 5'd0;

    // One bit per pipeline control driven by the sequencer
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_we;
        logic memwb_bubble;
        logic dmem_req;
    } ctrl_t;

    // Free-running pipeline: every stage advances, nothing flushed
    function automatic ctrl_t ctrl_run();
        ctrl_t c;
        c              = '0;
        c.pc_we        = 1'b1;
        c.ifid_we      = 1'b1;
        c.idex_we      = 1'b1;
        c.exmem_we     = 1'b1;
        c.memwb_we     = 1'b1;
        return c;
    endfunction

    // RUN-rule decode; a taken branch makes the ID instruction wrong-path,
    // so it wins over the load-use stall.
    function automatic ctrl_t ctrl_run_hazard(input logic lu, input logic taken);
        ctrl_t c;
        c = ctrl_run();
        if (taken) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (lu) begin
            c.pc_we      = 1'b0;
            c.ifid_we    = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

    // Memory freeze: front of the pipe holds, WB retires once behind a bubble
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c              = '0;
        c.memwb_we     = 1'b1;
        c.memwb_bubble = 1'b1;
        c.dmem_req     = 1'b1;
        return c;
    endfunction

    // Reset: nothing written, every stage cleared
    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c              = '0;
        c.ifid_flush   = 1'b1;
        c.idex_flush   = 1'b1;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

    // Timeout lock-up: pipeline frozen, memory request withdrawn
    function automatic ctrl_t ctrl_err();
        ctrl_t c;
        c              = '0;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_lu.sv
// Load-use hazard compare between the load in EX and the sources of the
// instruction in ID. Loads into $zero never create a dependency.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       lu
);

    // Raise lu when the ID instruction reads the register the EX load writes
    always_comb begin
        lu = idex_memread && (idex_rt != REG_ZERO) &&
             ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS-Lite pipeline.
// Outputs are combinational from state and inputs; wait/stall counters
// and the sticky timeout flag are registered.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_taken,
    input  logic             exmem_memop,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    localparam int unsigned      WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_q, err_d;
    logic              lu;
    ctrl_t             c;

    load_use_detect u_lu (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .lu           (lu)
    );

    // Output decode and next-state logic for the RUN/MEM_WAIT/ERR sequencer
    always_comb begin
        c       = ctrl_run();
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        if (!rst) begin
            c = ctrl_reset();
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (exmem_memop && !dmem_ack) begin
                        c       = ctrl_freeze();
                        state_d = ST_MEM_WAIT;
                        wait_d  = '0;
                    end else begin
                        c          = ctrl_run_hazard(lu, ex_taken);
                        c.dmem_req = exmem_memop;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        c          = ctrl_run_hazard(lu, ex_taken);
                        c.dmem_req = 1'b1;
                        state_d    = ST_RUN;
                        wait_d     = '0;
                    end else begin
                        c = ctrl_freeze();
                        if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    c = ctrl_err();
                end
                default: begin
                    c       = ctrl_err();
                    state_d = ST_ERR;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held
    always_comb begin
        stall_d = stall_q;
        if (!c.pc_we && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State, counters and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req     = c.dmem_req;
    assign pc_we        = c.pc_we;
    assign ifid_we      = c.ifid_we;
    assign ifid_flush   = c.ifid_flush;
    assign idex_we      = c.idex_we;
    assign idex_flush   = c.idex_flush;
    assign exmem_we     = c.exmem_we;
    assign memwb_we     = c.memwb_we;
    assign memwb_bubble = c.memwb_bubble;
    assign stall_cnt    = stall_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed stimulus with literal expectations
// plus a per-cycle behavioural model compared on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    id_rs = '0, id_rt = '0, idex_rt = '0;
    logic          id_uses_rt = 1'b0, idex_memread = 1'b0, ex_taken = 1'b0;
    logic          exmem_memop = 1'b0, dmem_ack = 1'b0;
    logic          dmem_req, pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic          exmem_we, memwb_we, memwb_bubble, err;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_taken(ex_taken), .exmem_memop(exmem_memop), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .memwb_bubble(memwb_bubble),
        .stall_cnt(stall_cnt), .err(err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model state as seen now (m_*) and after the coming rising edge (p_*)
    bit m_wait = 0, m_err = 0;
    int m_wcnt = 0, m_scnt = 0;
    bit p_wait = 0, p_err = 0;
    int p_wcnt = 0, p_scnt = 0;

    always @(negedge clk) begin
        bit lu, blk;
        bit e_pc, e_ifwe, e_iffl, e_idwe, e_idfl, e_exwe, e_mwwe, e_bub, e_req;
        m_wait = p_wait; m_err = p_err; m_wcnt = p_wcnt; m_scnt = p_scnt;
        if (!rst) begin
            m_wait = 0; m_err = 0; m_wcnt = 0; m_scnt = 0;
        end
        lu  = idex_memread && (idex_rt != 0) &&
              ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
        blk = 0;
        if (!rst) begin
            {e_pc, e_ifwe, e_idwe, e_exwe, e_mwwe, e_req} = '0;
            {e_iffl, e_idfl, e_bub} = '1;
        end else if (m_err) begin
            {e_pc, e_ifwe, e_idwe, e_exwe, e_mwwe, e_req, e_iffl, e_idfl} = '0;
            e_bub = 1;
        end else begin
            blk = m_wait ? !dmem_ack : (exmem_memop && !dmem_ack);
            if (blk) begin
                {e_pc, e_ifwe, e_idwe, e_exwe, e_iffl, e_idfl} = '0;
                {e_mwwe, e_bub, e_req} = '1;
            end else begin
                e_idwe = 1; e_exwe = 1; e_mwwe = 1; e_bub = 0;
                e_req  = m_wait || exmem_memop;
                e_iffl = ex_taken;
                e_idfl = ex_taken || lu;
                e_pc   = ex_taken || !lu;
                e_ifwe = ex_taken || !lu;
            end
        end
        chk("m pc_we",        pc_we,        e_pc);
        chk("m ifid_we",      ifid_we,      e_ifwe);
        chk("m ifid_flush",   ifid_flush,   e_iffl);
        chk("m idex_we",      idex_we,      e_idwe);
        chk("m idex_flush",   idex_flush,   e_idfl);
        chk("m exmem_we",     exmem_we,     e_exwe);
        chk("m memwb_we",     memwb_we,     e_mwwe);
        chk("m memwb_bubble", memwb_bubble, e_bub);
        chk("m dmem_req",     dmem_req,     e_req);
        chk("m stall_cnt",    stall_cnt,    m_scnt);
        chk("m err",          err,          m_err);
        // advance the model to the state after the next rising edge
        p_wait = m_wait; p_err = m_err; p_wcnt = m_wcnt; p_scnt = m_scnt;
        if (rst) begin
            if (!e_pc && m_scnt < SAT) p_scnt = m_scnt + 1;
            if (!m_err) begin
                if (blk && m_wait) begin
                    p_wcnt = m_wcnt + 1;
                    if (TO != 0 && p_wcnt == TO) p_err = 1;
                end else if (blk) begin
                    p_wait = 1; p_wcnt = 0;
                end else begin
                    p_wait = 0; p_wcnt = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        id_rs = '0; id_rt = '0; idex_rt = '0; id_uses_rt = 0;
        idex_memread = 0; ex_taken = 0; exmem_memop = 0; dmem_ack = 0;
    endtask

    initial begin
        clear_in();
        repeat (2) step();
        settle();
        chk("rst pc_we", pc_we, 0);
        chk("rst ifid_flush", ifid_flush, 1);
        chk("rst memwb_bubble", memwb_bubble, 1);
        chk("rst stall_cnt", stall_cnt, 0);
        rst = 1;
        settle();
        chk("run pc_we", pc_we, 1);
        chk("run memwb_we", memwb_we, 1);
        step();

        // load-use on rs
        idex_memread = 1; idex_rt = 5'd8; id_rs = 5'd8;
        settle();
        chk("lu pc_we", pc_we, 0);
        chk("lu ifid_we", ifid_we, 0);
        chk("lu idex_flush", idex_flush, 1);
        chk("lu exmem_we", exmem_we, 1);
        step(); clear_in(); settle();
        chk("lu after pc_we", pc_we, 1);
        chk("lu after stall_cnt", stall_cnt, 1);

        // $zero load and rt compare gated by id_uses_rt
        idex_memread = 1; idex_rt = 5'd0; id_rs = 5'd0;
        settle(); chk("zero pc_we", pc_we, 1);
        step(); idex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 0;
        settle(); chk("rt unused pc_we", pc_we, 1);
        step(); id_uses_rt = 1;
        settle(); chk("rt used pc_we", pc_we, 0);
        step(); clear_in(); settle();
        chk("rt stall_cnt", stall_cnt, 2);

        // taken branch overrides load-use
        idex_memread = 1; idex_rt = 5'd8; id_rs = 5'd8; ex_taken = 1;
        settle();
        chk("br ifid_flush", ifid_flush, 1);
        chk("br idex_flush", idex_flush, 1);
        chk("br pc_we", pc_we, 1);
        chk("br ifid_we", ifid_we, 1);
        step(); clear_in(); settle();
        chk("br stall_cnt", stall_cnt, 2);

        // memory wait: three freeze cycles then ack
        exmem_memop = 1; dmem_ack = 0;
        settle();
        chk("mw0 dmem_req", dmem_req, 1);
        chk("mw0 exmem_we", exmem_we, 0);
        chk("mw0 memwb_bubble", memwb_bubble, 1);
        step(); settle(); chk("mw1 pc_we", pc_we, 0);
        step(); settle(); chk("mw2 memwb_bubble", memwb_bubble, 1);
        step(); dmem_ack = 1; settle();
        chk("mwx pc_we", pc_we, 1);
        chk("mwx memwb_bubble", memwb_bubble, 0);
        chk("mwx dmem_req", dmem_req, 1);
        step(); clear_in(); settle();
        chk("mw stall_cnt", stall_cnt, 5);

        // timeout with TIMEOUT = 4
        exmem_memop = 1; dmem_ack = 0;
        repeat (4) step();
        settle(); chk("to pre err", err, 0);
        step(); settle();
        chk("to err", err, 1);
        chk("to dmem_req", dmem_req, 0);
        chk("to stall_cnt", stall_cnt, 10);
        dmem_ack = 1; settle();
        chk("to late ack pc_we", pc_we, 0);
        chk("to late ack dmem_req", dmem_req, 0);
        step(); settle();
        chk("to stall_cnt2", stall_cnt, 11);
        repeat (6) step();
        settle(); chk("sat stall_cnt", stall_cnt, SAT);

        // reset in the middle of MEM_WAIT
        clear_in(); rst = 0; step(); rst = 1; settle();
        exmem_memop = 1; dmem_ack = 0;
        step(); step(); settle();
        chk("rmw dmem_req", dmem_req, 1);
        rst = 0; settle();
        chk("rmw rst dmem_req", dmem_req, 0);
        chk("rmw rst stall_cnt", stall_cnt, 0);
        step(); clear_in(); rst = 1; settle();
        chk("rel err", err, 0);
        chk("rel pc_we", pc_we, 1);
        chk("rel memwb_bubble", memwb_bubble, 0);
        step(); settle();
        chk("rel stall_cnt", stall_cnt, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
